// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with fixed or round-robin select and a registered output stage.
module stream_mux_rr #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_q, last_d;
  logic [SELW-1:0]  grant, rr_idx;
  logic             grant_vld, load;
  // Scan offsets from farthest to nearest so the channel closest after last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    rr_idx    = '0;
    if (mode) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        rr_idx = SELW'((int'(last_q) + 1 + i) % NCH);
        if (in_valid[rr_idx]) begin
          grant_vld = 1'b1;
          grant     = rr_idx;
        end
      end
    end else if (int'(sel) < NCH) begin
      grant_vld = in_valid[sel];
      grant     = sel;
    end
  end
  always_comb begin
    load        = !out_valid_q || out_ready;
    in_ready    = (rst_n && load && grant_vld) ? NCH'(1) << grant : '0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load && grant_vld) begin
      out_data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      last_d      = grant;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and random checks of stream_mux_rr against a behavioural model.
module tb_stream_mux_rr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] in_valid = '0, in_ready;
  logic       mode = 1'b0, out_ready = 1'b0, out_valid;
  logic [1:0] sel = '0, out_data, out_ch;
  logic [5:0] in_data3 = '0;
  logic [2:0] in_valid3 = '0, in_ready3;
  logic       mode3 = 1'b0, out_ready3 = 1'b0, out_valid3;
  logic [1:0] sel3 = '0, out_data3, out_ch3;
  int checks = 0, errors = 0;
  int m_last = 3, m_ch = 0, m_data = 0;
  bit m_valid = 0;

  stream_mux_rr dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch)
  );
  stream_mux_rr #(.WIDTH(2), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_ch(out_ch3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grant: fixed channel if valid, else first valid channel after the last winner.
  function automatic int ref_grant();
    if (!mode) return (int'(sel) < 4 && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++)
      if (in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic step();
    int  g;
    bit  ld;
    g  = ref_grant();
    ld = !m_valid || out_ready;
    #1;
    chk("in_ready", 32'(in_ready), (ld && g >= 0) ? 32'(1) << g : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    @(posedge clk);
    if (ld && g >= 0) begin
      m_valid = 1;
      m_data  = int'(in_data[g*2 +: 2]);
      m_ch    = g;
      m_last  = g;
    end else if (ld) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_sparse[4] = '{3, 1, 3, 1};
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Three-channel build: out-of-range select drains then empties.
    in_data3 = 6'b10_01_00; in_valid3 = 3'b111; sel3 = 2'd2; out_ready3 = 1'b1;
    step();
    chk("n3_valid", 32'(out_valid3), 1);
    chk("n3_ch", 32'(out_ch3), 2);
    chk("n3_data", 32'(out_data3), 2);
    sel3 = 2'd3;
    #1;
    chk("n3_oor_ready", 32'(in_ready3), 0);
    chk("n3_pending", 32'(out_valid3), 1);
    @(negedge clk);
    chk("n3_drained", 32'(out_valid3), 0);
    sel3 = 2'd0; in_valid3 = '0;
    @(negedge clk);
    chk("n3_empty", 32'(out_valid3), 0);
    // Fixed select.
    in_data = 8'b11_10_01_00; in_valid = 4'hf; out_ready = 1'b1; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      chk("fix_data", 32'(out_data), 32'(s));
      chk("fix_ch", 32'(out_ch), 32'(s));
      chk("fix_valid", 32'(out_valid), 1);
    end
    // Round-robin over all channels.
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_ch", 32'(out_ch), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(i % 4));
    end
    // Sparse round-robin, then a single channel.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sparse_ch", 32'(out_ch), 32'(exp_sparse[i]));
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_ch", 32'(out_ch), 1);
    end
    // Backpressure holds the beat and blocks every input.
    in_valid = 4'hf;
    step();
    chk("bp_first", 32'(out_ch), 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ch", 32'(out_ch), 2);
      chk("bp_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume", 32'(out_ch), 3);
    in_valid = '0;
    step();
    chk("empty_valid", 32'(out_valid), 0);
    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_data   = 8'($urandom);
      in_valid  = 4'($urandom);
      mode      = 1'($urandom_range(0, 3) != 0);
      sel       = 2'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    // Asynchronous reset between edges.
    in_valid = 4'hf; out_ready = 1'b1; mode = 1'b1; in_data = 8'b11_10_01_00;
    step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_ch", 32'(out_ch), 0);
    chk("arst_ready", 32'(in_ready), 0);
    #1 rst_n = 1'b1;
    m_valid = 0; m_data = 0; m_ch = 0; m_last = 3;
    @(negedge clk);
    in_valid = 4'hf;
    step();
    chk("post_rst_ch", 32'(out_ch), 0);
    chk("post_rst_valid", 32'(out_valid), 1);
    step();
    chk("post_rst_ch2", 32'(out_ch), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output, plus a registered output stage. It selects one channel per transfer, either a fixed channel chosen by `sel` or a fair round-robin across all valid channels. It is the sequential successor to the plain combinational 4:1 mux and sits between several producers and a single consumer that can apply backpressure.

## Interface
- `WIDTH`, default 2: data bits per channel (≥1).
- `NCH`, default 4: number of input channels (2..16).
- `SELW`, default `$clog2(NCH)`: derived select/channel-index width; do not override.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in_data`  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  input  NCH  channel k has data.
- `in_ready`  output  NCH  channel k's data is accepted this cycle; at most one bit high.
- `mode`  input  1  0 = fixed select, 1 = round-robin.
- `sel`  input  SELW  channel index used when mode=0.
- `out_data`  output  WIDTH  registered data.
- `out_valid`  output  1  output register holds data.
- `out_ready`  input  1  consumer accepts out_data this cycle.
- `out_ch`  output  SELW  index of the channel that supplied out_data.

## Operation
- One-entry output register (data, channel, valid flag). Define `load = !out_valid || out_ready`.
- Grant, evaluated combinationally each cycle from the current in_valid/mode/sel:
  - mode=0: grant channel `sel` iff `sel < NCH` and `in_valid[sel]`. Otherwise there is no grant.
  - mode=1: grant the first channel with in_valid=1, searching from `last+1` upward and wrapping NCH-1 → 0. `last` is checked last. No valid channel means no grant.
- `in_ready[g] = load && grant==g`. All other in_ready bits are 0. in_ready may depend combinationally on in_valid, mode, sel and out_ready.
- Transfer on channel g occurs when `in_valid[g] && in_ready[g]`. On the next edge: out_data ← in_data[g], out_ch ← g, out_valid ← 1.
- If load=1 and there is no grant, out_valid ← 0 on the next edge; out_data and out_ch hold.
- If load=0, the output register holds all fields.
- `last` ← g only on an accepted transfer, in either mode. Fixed-mode transfers therefore also move the round-robin pointer.
- Changing mode or sel takes effect on the very next grant evaluation. A beat already in the output register is unaffected.
- Inputs must hold data stable while valid and not ready. The block does not check this.

## Timing
- Reset (rst_n=0, takes effect immediately, asynchronously): out_valid=0, out_data=0, out_ch=0, last=NCH-1 (so channel 0 has first priority), all in_ready=0.
- A reset asserted mid-operation drops any held beat. The first grant after release follows reset priority.
- Latency: input acceptance to out_valid is 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1. With out_ready held high there are no bubbles.
- Simultaneous drain and refill: when out_valid=1, out_ready=1 and a grant exists, the new beat replaces the old one on the same edge.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready are 0 and out_data, out_ch and out_valid are stable until out_ready rises.
- Round-robin fairness: with all NCH channels continuously valid and out_ready=1, grants follow the sequence 0,1,…,NCH-1,0,… One channel can never be granted twice while another is continuously valid and waiting.

## Test plan
- Fixed select (NCH=4, WIDTH=2): d0..d3 = 0,1,2,3, all valid, out_ready=1, sel stepped 0→1→2→3 every 10 ns → one cycle after each step out_data equals sel, out_ch equals sel, out_valid=1.
- Round-robin: all four channels valid, mode=1, out_ready=1 from reset → out_ch sequence 0,1,2,3,0,1 on consecutive cycles with out_data equal to the matching d value. Only the granted in_ready bit is high each cycle.
- Sparse round-robin: only channels 1 and 3 valid → out_ch alternates 1,3,1,3. Then channel 1 alone stays valid while 3 is dropped → out_ch stays 1.
- Backpressure: mode=1, all valid, out_ready=0 for 3 cycles after the first beat → out_valid=1, out_ch=0 held, in_ready=0000. When out_ready returns to 1 → next out_ch=1.
- Out-of-range/empty: NCH=3 build with sel=3, mode=0 → in_ready=000 and out_valid falls to 0 after the pending beat drains. With all in_valid=0 → out_valid=0.
- Reset mid-stream: rst_n pulsed low between clock edges while out_valid=1 → out_valid, out_data and out_ch are 0 immediately. After release with all valid, the first grant is channel 0.
